// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-pointer helpers and pointer-width convention for the FIFO stages.
package gray_pkg;
  localparam int ASIZE_DEF = 4;
  localparam int PTR_W = ASIZE_DEF + 1;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/bin_2_gray.sv
// bin_2_gray: combinational binary to Gray conversion of a size-bit value.
module bin_2_gray import gray_pkg::*; #(
  parameter int size = PTR_W
) (
  input  logic [size-1:0] bin,
  output logic [size-1:0] gray
);
  logic [31:0] g32;
  assign g32 = bin2gray(32'(bin));
  assign gray = g32[size-1:0];
endmodule

// File: rtl/gray_sync_2ff.sv
// gray_sync_2ff: two-flop synchroniser for a Gray pointer crossing clock domains.
module gray_sync_2ff #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
endmodule

// File: rtl/gray_wptr_full.sv
// gray_wptr_full: write pointer, exported Gray pointer and registered full flag of a Gray-pointer FIFO.
module gray_wptr_full import gray_pkg::*; #(
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ASIZE:0]   rptr_gray_async,
  output logic             push_ok,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr_gray,
  output logic             full,
  output logic             overflow
);
  localparam int W = ASIZE + 1;
  logic [W-1:0] wbin, wbin_next, wgray_next, rq2;
  assign push_ok = push & ~full;
  assign wbin_next = wbin + W'(push_ok);
  assign waddr = wbin[ASIZE-1:0];
  bin_2_gray #(.size(W)) u_b2g (.bin(wbin_next), .gray(wgray_next));
  gray_sync_2ff #(.W(W)) u_sync (.clk(clk), .rst(rst), .d(rptr_gray_async), .q(rq2));
  // Full when the next write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wbin      <= '0;
      wptr_gray <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      full      <= (wgray_next == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]});
      overflow  <= overflow | (push & full);
    end
endmodule
